// File: rtl/ceres_param.sv
// ceres_param: shared constants and FSM encoding for the UART program loader.
package ceres_param;

    localparam logic [71:0] PROGRAM_SEQUENCE = "ceresTEST";
    localparam int          PROG_BAUD_RATE   = 115200;
    localparam logic [7:0]  ACK_BYTE         = 8'h06;
    localparam logic [7:0]  NAK_BYTE         = 8'h15;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_RESP
    } state_e;

endpackage

// File: rtl/loader_magic_detector.sv
// loader_magic_detector: sliding byte window that pulses match_o when the newest bytes equal MAGIC_SEQ.
module loader_magic_detector
    import ceres_param::*;
#(
    parameter int                   SEQ_LEN   = 9,
    parameter logic [SEQ_LEN*8-1:0] MAGIC_SEQ = PROGRAM_SEQUENCE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] byte_i,
    input  logic       valid_i,
    output logic       match_o
);

    // Only the previous SEQ_LEN-1 bytes are stored; the incoming byte completes the window.
    logic [(SEQ_LEN-1)*8-1:0] win_q;
    logic [SEQ_LEN*8-1:0]     win_d;

    assign win_d   = {win_q, byte_i};
    assign match_o = valid_i && (win_d == MAGIC_SEQ);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            win_q <= '0;
        else if (valid_i)
            win_q <= match_o ? '0 : win_d[(SEQ_LEN-1)*8-1:0];
    end

endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: byte-stream protocol engine that hunts a magic sequence, then loads
// a checksummed image into memory while holding the CPU in reset.
module uart_mem_loader
    import ceres_param::*;
#(
    parameter int                   DATA_W         = 32,
    parameter int                   ADDR_W         = 32,
    parameter int                   SEQ_LEN        = 9,
    parameter logic [SEQ_LEN*8-1:0] MAGIC_SEQ      = PROGRAM_SEQUENCE,
    parameter int                   TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic              prog_mode_o,
    output logic              system_reset_o,
    output logic              error_o
);

    localparam int NB = DATA_W / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic [23:0]       hdr_q, hdr_d;
    logic [31:0]       hdr_nx;
    logic [31:0]       len_q, len_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        resp_q, resp_d;
    logic [TW-1:0]     tout_q, tout_d;
    logic              err_q, err_d;
    logic              srst_q, srst_d;
    logic              rx_fire, match, waiting, timeout;

    assign rx_ready_o = !rst_i && state_q != ST_WRITE && state_q != ST_RESP;
    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign hdr_nx     = {hdr_q, rx_data_i};
    assign waiting    = state_q inside {ST_ADDR, ST_LEN, ST_DATA, ST_CSUM};
    assign timeout    = waiting && !rx_fire && tout_q == TW'(TIMEOUT_CYCLES - 1);

    assign tx_data_o      = resp_q;
    assign tx_valid_o     = state_q == ST_RESP;
    assign mem_addr_o     = addr_q;
    assign mem_data_o     = data_q;
    assign mem_valid_o    = state_q == ST_WRITE;
    assign prog_mode_o    = state_q != ST_HUNT;
    assign system_reset_o = srst_q;
    assign error_o        = err_q;

    loader_magic_detector #(
        .SEQ_LEN  (SEQ_LEN),
        .MAGIC_SEQ(MAGIC_SEQ)
    ) u_magic (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .byte_i (rx_data_i),
        .valid_i(rx_fire && state_q == ST_HUNT),
        .match_o(match)
    );

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        bcnt_d  = bcnt_q;
        csum_d  = csum_q;
        resp_d  = resp_q;
        err_d   = err_q;
        srst_d  = srst_q;
        tout_d  = rx_fire ? '0 : waiting ? tout_q + TW'(1) : tout_q;
        case (state_q)
            ST_HUNT: if (match) begin
                state_d = ST_ADDR;
                err_d   = 1'b0;
                srst_d  = 1'b1;
                csum_d  = '0;
                bcnt_d  = '0;
                cnt_d   = '0;
            end
            ST_ADDR: if (rx_fire) begin
                hdr_d  = hdr_nx[23:0];
                bcnt_d = bcnt_q == 3'd3 ? 3'd0 : bcnt_q + 3'd1;
                if (bcnt_q == 3'd3) begin
                    addr_d  = ADDR_W'(hdr_nx);
                    state_d = ST_LEN;
                end
            end
            ST_LEN: if (rx_fire) begin
                hdr_d  = hdr_nx[23:0];
                bcnt_d = bcnt_q == 3'd3 ? 3'd0 : bcnt_q + 3'd1;
                if (bcnt_q == 3'd3) begin
                    len_d   = hdr_nx;
                    state_d = hdr_nx == '0 ? ST_CSUM : ST_DATA;
                end
            end
            ST_DATA: if (rx_fire) begin
                data_d[{bcnt_q, 3'b000} +: 8] = rx_data_i;
                csum_d  = csum_q + rx_data_i;
                bcnt_d  = bcnt_q == 3'(NB - 1) ? 3'd0 : bcnt_q + 3'd1;
                state_d = bcnt_q == 3'(NB - 1) ? ST_WRITE : ST_DATA;
            end
            ST_WRITE: if (mem_ready_i) begin
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q + 32'd1;
                state_d = cnt_q + 32'd1 == len_q ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: if (rx_fire) begin
                resp_d  = rx_data_i == csum_q ? ACK_BYTE : NAK_BYTE;
                state_d = ST_RESP;
            end
            ST_RESP: if (tx_ready_i) begin
                state_d = ST_HUNT;
                srst_d  = resp_q != ACK_BYTE;
                err_d   = err_q || resp_q != ACK_BYTE;
            end
            default: state_d = ST_HUNT;
        endcase
        // Abandoned load: CPU stays held, no response is sent.
        if (timeout) begin
            state_d = ST_HUNT;
            err_d   = 1'b1;
            tout_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_HUNT;
            hdr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            bcnt_q  <= '0;
            csum_q  <= '0;
            resp_q  <= '0;
            tout_q  <= '0;
            err_q   <= 1'b0;
            srst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            bcnt_q  <= bcnt_d;
            csum_q  <= csum_d;
            resp_q  <= resp_d;
            tout_q  <= tout_d;
            err_q   <= err_d;
            srst_q  <= srst_d;
        end
    end

endmodule
